// File: rtl/sort_engine_pkg.sv
// ----------------------------------------------------------------------------
// sort_engine_pkg: shared types and helpers for the sort engine merge stage.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sort_engine_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOP = 2'd1,
      MERGE    = 2'd2,
      FLUSH    = 2'd3
   } merge_state_t;

   localparam logic SORT_ASC  = 1'b0;
   localparam logic SORT_DESC = 1'b1;

   // Packet length width: room for ENGINE_CNT full packets plus one spare bit.
   function automatic int len_width(input int aw, input int ec);
      return aw + $clog2(ec) + 1;
   endfunction

   function automatic int idx_width(input int ec);
      return (ec > 1) ? $clog2(ec) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sort_kway_select.sv
// ----------------------------------------------------------------------------
// sort_kway_select: single-cycle min/max tree returning the winning channel.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sort_kway_select
   import sort_engine_pkg::*;
#(
   parameter int  DWIDTH     = 32,
   parameter int  ENGINE_CNT = 4,
   localparam int IW         = idx_width(ENGINE_CNT)
) (
   input  logic [ENGINE_CNT*DWIDTH-1:0] heads_i,
   input  logic [ENGINE_CNT-1:0]        elig_i,
   input  logic                         desc_i,
   output logic [IW-1:0]                win_o
);

   localparam int LEVELS = $clog2(ENGINE_CNT);
   localparam int P      = 1 << LEVELS;

   // Pairwise reduction; the left (lower index) operand wins on equality.
   function automatic logic [IW-1:0] f_pick(
      input logic [ENGINE_CNT*DWIDTH-1:0] heads,
      input logic [ENGINE_CNT-1:0]        elig,
      input logic                         desc
   );
      logic [P*DWIDTH-1:0] hp;
      logic [P-1:0]        v;
      logic [DWIDTH-1:0]   d  [P];
      logic [IW-1:0]       ix [P];
      hp = '0;
      v  = '0;
      hp[ENGINE_CNT*DWIDTH-1:0] = heads;
      v[ENGINE_CNT-1:0]         = elig;
      for (int j = 0; j < P; j++) begin
         d[j]  = hp[j*DWIDTH +: DWIDTH];
         ix[j] = IW'(j);
      end
      for (int s = 1; s < P; s = s * 2) begin
         for (int j = 0; j + s < P; j = j + 2 * s) begin
            if (v[j+s] && (!v[j] || (desc ? (d[j+s] > d[j]) : (d[j+s] < d[j])))) begin
               d[j]  = d[j+s];
               ix[j] = ix[j+s];
            end
            v[j] = v[j] | v[j+s];
         end
      end
      return ix[0];
   endfunction

   assign win_o = f_pick(heads_i, elig_i, desc_i);

endmodule

`default_nettype wire

// File: rtl/sort_kway_merge.sv
// ----------------------------------------------------------------------------
// sort_kway_merge: merges ENGINE_CNT sorted packets into one sorted packet.
// Define SORT_MERGE_CHECK_EN to add the input order/framing checker (err_o).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sort_kway_merge
   import sort_engine_pkg::*;
#(
   parameter int  AWIDTH     = 10,
   parameter int  DWIDTH     = 32,
   parameter int  ENGINE_CNT = 4,
   localparam int LWIDTH     = len_width(AWIDTH, ENGINE_CNT)
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         desc_i,
   input  logic [ENGINE_CNT*DWIDTH-1:0] data_i,
   input  logic [ENGINE_CNT-1:0]        sop_i,
   input  logic [ENGINE_CNT-1:0]        eop_i,
   input  logic [ENGINE_CNT-1:0]        val_i,
   output logic [ENGINE_CNT-1:0]        ready_o,
   output logic [DWIDTH-1:0]            data_o,
   output logic                         sop_o,
   output logic                         eop_o,
   output logic                         val_o,
   input  logic                         ready_i,
   output logic [LWIDTH-1:0]            len_o,
`ifdef SORT_MERGE_CHECK_EN
   output logic                         err_o,
`endif
   output logic                         busy_o
);

   localparam int IW = idx_width(ENGINE_CNT);

   merge_state_t          state_q, state_d;
   logic                  desc_q;
   logic [ENGINE_CNT-1:0] done_q, done_d;
   logic [ENGINE_CNT-1:0] armed_q;
   logic [LWIDTH-1:0]     cnt_q, cnt_d;
   logic                  val_q, sop_q, eop_q;
   logic [DWIDTH-1:0]     data_q;
   logic [LWIDTH-1:0]     len_q;

   logic [IW-1:0]         win;
   logic [ENGINE_CNT-1:0] win_oh;
   logic [DWIDTH-1:0]     win_data;
   logic                  all_val, out_free, take, last;

   sort_kway_select #(
      .DWIDTH     (DWIDTH),
      .ENGINE_CNT (ENGINE_CNT)
   ) u_select (
      .heads_i (data_i),
      .elig_i  (~done_q),
      .desc_i  (desc_q),
      .win_o   (win)
   );

   assign all_val  = &(val_i | done_q);
   assign out_free = ~val_q | ready_i;
   assign win_data = data_i[win*DWIDTH +: DWIDTH];

   always_comb begin
      state_d = state_q;
      ready_o = '0;
      take    = 1'b0;
      for (int c = 0; c < ENGINE_CNT; c++) begin
         win_oh[c] = (win == IW'(c));
      end
      done_d = done_q | (win_oh & eop_i);
      last   = &done_d;
      cnt_d  = (&cnt_q) ? cnt_q : cnt_q + LWIDTH'(1);
      case (state_q)
         IDLE: state_d = WAIT_SOP;
         WAIT_SOP: begin
            // Unarmed heads without sop are stray words: drain them.
            ready_o = val_i & ~sop_i & ~armed_q;
            if (&(armed_q | (val_i & sop_i))) state_d = MERGE;
         end
         MERGE: begin
            if (all_val && out_free) begin
               take    = 1'b1;
               ready_o = win_oh;
               if (last) state_d = FLUSH;
            end
         end
         FLUSH: if (out_free) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         desc_q  <= SORT_ASC;
         done_q  <= '0;
         armed_q <= '0;
         cnt_q   <= '0;
         val_q   <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         data_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) begin
            desc_q  <= desc_i;
            done_q  <= '0;
            armed_q <= '0;
            cnt_q   <= '0;
         end
         if (state_q == WAIT_SOP) armed_q <= armed_q | (val_i & sop_i);
         if (take) begin
            done_q <= done_d;
            cnt_q  <= cnt_d;
            len_q  <= cnt_d;
            data_q <= win_data;
            val_q  <= 1'b1;
            sop_q  <= (cnt_q == '0);
            eop_q  <= last;
         end else if (ready_i) begin
            val_q <= 1'b0;
         end
      end
   end

   assign data_o = data_q;
   assign sop_o  = sop_q;
   assign eop_o  = eop_q;
   assign val_o  = val_q;
   assign len_o  = len_q;
   assign busy_o = (state_q != IDLE);

`ifdef SORT_MERGE_CHECK_EN
   logic [DWIDTH-1:0]     last_q [ENGINE_CNT];
   logic [ENGINE_CNT-1:0] seen_q;
   logic                  err_q;

   // Each channel is compared only against its own previous word.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         err_q  <= 1'b0;
         seen_q <= '0;
         for (int c = 0; c < ENGINE_CNT; c++) last_q[c] <= '0;
      end else begin
         if (state_q == IDLE) seen_q <= '0;
         if (state_q == WAIT_SOP && |(val_i & ~sop_i & ~armed_q)) err_q <= 1'b1;
         if (take) begin
            if (seen_q[win]) begin
               if (sop_i[win]) err_q <= 1'b1;
               if (desc_q ? (win_data > last_q[win]) : (win_data < last_q[win])) err_q <= 1'b1;
            end
            last_q[win] <= win_data;
            seen_q[win] <= 1'b1;
         end
      end
   end

   assign err_o = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sort_kway_merge.sv
// ----------------------------------------------------------------------------
// tb_sort_kway_merge: self-checking bench for sort_kway_merge.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sort_kway_merge;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int EC = 4;
   localparam int LW = AW + $clog2(EC) + 1;

   logic             clk = 1'b0;
   logic             rst_n_i;
   logic             desc_i;
   logic [EC*DW-1:0] data_i;
   logic [EC-1:0]    sop_i, eop_i, val_i, ready_o;
   logic [DW-1:0]    data_o;
   logic             sop_o, eop_o, val_o, ready_i, busy_o;
   logic [LW-1:0]    len_o;
`ifdef SORT_MERGE_CHECK_EN
   logic             err_o;
   bit               err_hist[$];
`endif

   always #5 clk = ~clk;

   sort_kway_merge #(.AWIDTH(AW), .DWIDTH(DW), .ENGINE_CNT(EC)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n_i),
      .desc_i  (desc_i),
      .data_i  (data_i),
      .sop_i   (sop_i),
      .eop_i   (eop_i),
      .val_i   (val_i),
      .ready_o (ready_o),
      .data_o  (data_o),
      .sop_o   (sop_o),
      .eop_o   (eop_o),
      .val_o   (val_o),
      .ready_i (ready_i),
      .len_o   (len_o),
`ifdef SORT_MERGE_CHECK_EN
      .err_o   (err_o),
`endif
      .busy_o  (busy_o)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned ch_q [EC][$];
   int          sent [EC];
   int unsigned got_d[$];
   bit          got_sop[$], got_eop[$];
   int          take_ch[$], take_cyc[$];
   int          got_len, stall_bad, gap_xfers, gap_outs, first_out, last_out;
   bit          timed_out;

   task automatic clear_chans();
      for (int c = 0; c < EC; c++) begin
         ch_q[c].delete();
         sent[c] = 0;
      end
   endtask

   task automatic do_reset(input logic d);
      @(negedge clk);
      rst_n_i = 1'b0; desc_i = d; ready_i = 1'b1;
      val_i = '0; sop_i = '0; eop_i = '0; data_i = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n_i = 1'b1;
   endtask

   // Feeds the channel queues cycle by cycle and records what leaves the DUT.
   task automatic run_pkt(input int rdy_mode, input bit tog_desc, input int gap_ch,
                          input int gap_s, input int gap_n, input int rst_after);
      bit            fin, prev_stall, prev_s, prev_e;
      logic [DW-1:0] prev_d;
      bit            in_gap;
      got_d.delete(); got_sop.delete(); got_eop.delete();
      take_ch.delete(); take_cyc.delete();
`ifdef SORT_MERGE_CHECK_EN
      err_hist.delete();
`endif
      got_len = -1; stall_bad = 0; gap_xfers = 0; gap_outs = 0;
      first_out = -1; last_out = -1; fin = 0; prev_stall = 0;
      prev_d = '0; prev_s = 0; prev_e = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         @(negedge clk);
         case (rdy_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = (cyc % 2 == 0);
            default: ready_i = 1'($urandom_range(0, 1));
         endcase
         if (tog_desc && cyc > 3) desc_i = ~desc_i;
         in_gap = (gap_ch >= 0) && (cyc >= gap_s) && (cyc < gap_s + gap_n);
         val_i = '0; sop_i = '0; eop_i = '0; data_i = '0;
         for (int c = 0; c < EC; c++) begin
            if (ch_q[c].size() > 0 && !(in_gap && c == gap_ch)) begin
               val_i[c] = 1'b1;
               data_i[c*DW +: DW] = ch_q[c][0];
               sop_i[c] = (sent[c] == 0);
               eop_i[c] = (ch_q[c].size() == 1);
            end
         end
         #1;
`ifdef SORT_MERGE_CHECK_EN
         err_hist.push_back(err_o);
`endif
         if (prev_stall && (val_o !== 1'b1 || data_o !== prev_d || sop_o !== prev_s || eop_o !== prev_e))
            stall_bad++;
         prev_stall = val_o && !ready_i;
         prev_d = data_o; prev_s = sop_o; prev_e = eop_o;
         if (gap_ch >= 0 && cyc > gap_s && cyc <= gap_s + gap_n && val_o) gap_outs++;
         if (val_o && ready_i) begin
            got_d.push_back(data_o);
            got_sop.push_back(sop_o);
            got_eop.push_back(eop_o);
            if (first_out < 0) first_out = cyc;
            if (eop_o) begin
               got_len = int'(len_o);
               last_out = cyc;
               fin = 1;
            end
         end
         for (int c = 0; c < EC; c++) begin
            if (val_i[c] && ready_o[c]) begin
               take_ch.push_back(c);
               take_cyc.push_back(cyc);
               if (in_gap) gap_xfers++;
               void'(ch_q[c].pop_front());
               sent[c]++;
            end
         end
         if (rst_after > 0 && got_d.size() == rst_after) begin
            rst_n_i = 1'b0;
            fin = 1;
         end
         @(posedge clk);
         if (fin) break;
      end
      timed_out = !fin;
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0; desc_i = 1'b0; ready_i = 1'b1;
      val_i = '1; sop_i = '1; eop_i = '0; data_i = '0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if ({val_o, sop_o, eop_o, busy_o} !== 4'b0 || ready_o !== '0 || data_o !== '0 || len_o !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got val=%b sop=%b eop=%b busy=%b rdy=%b data=%0d len=%0d, expected all 0",
                  val_o, sop_o, eop_o, busy_o, ready_o, data_o, len_o);
      end
`ifdef SORT_MERGE_CHECK_EN
      n_checks++;
      if (err_o !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
`endif
      rst_n_i = 1'b1;
      #1;
      n_checks++;
      if (busy_o !== 1'b0 || ready_o !== '0) begin
         n_errors++;
         $display("FAIL idle_after_reset: got busy=%b rdy=%b expected 0/0", busy_o, ready_o);
      end
      @(negedge clk); #1;
      n_checks++;
      if (busy_o !== 1'b1) begin n_errors++; $display("FAIL busy_wait_sop: got %b expected 1", busy_o); end
      val_i = '0;
   endtask

   task automatic test_asc();
      do_reset(1'b0);
      clear_chans();
      ch_q[0] = '{1, 5, 9}; ch_q[1] = '{2, 6}; ch_q[2] = '{0}; ch_q[3] = '{3, 4, 7, 8};
      run_pkt(0, 0, -1, 0, 0, 0);
      n_checks++;
      if (timed_out || got_d.size() != 10) begin
         n_errors++; $display("FAIL asc_count: got %0d words (timeout=%b) expected 10", got_d.size(), timed_out);
      end else begin
         for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (got_d[i] != i || got_sop[i] != (i == 0) || got_eop[i] != (i == 9)) begin
               n_errors++;
               $display("FAIL asc_word[%0d]: got %0d sop=%b eop=%b expected %0d sop=%b eop=%b",
                        i, got_d[i], got_sop[i], got_eop[i], i, i == 0, i == 9);
            end
         end
         n_checks++;
         if (got_len != 10) begin n_errors++; $display("FAIL asc_len: got %0d expected 10", got_len); end
         n_checks++;
         if (last_out - first_out != 9) begin
            n_errors++; $display("FAIL asc_throughput: got span %0d expected 9", last_out - first_out);
         end
      end
   endtask

   task automatic test_desc();
      do_reset(1'b1);
      clear_chans();
      ch_q[0] = '{9, 5, 1}; ch_q[1] = '{6, 2}; ch_q[2] = '{0}; ch_q[3] = '{8, 7, 4, 3};
      run_pkt(0, 1, -1, 0, 0, 0);
      n_checks++;
      if (timed_out || got_d.size() != 10) begin
         n_errors++; $display("FAIL desc_count: got %0d words (timeout=%b) expected 10", got_d.size(), timed_out);
      end else begin
         for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (got_d[i] != 9 - i) begin
               n_errors++; $display("FAIL desc_word[%0d]: got %0d expected %0d", i, got_d[i], 9 - i);
            end
         end
      end
   endtask

   task automatic test_ties();
      do_reset(1'b0);
      clear_chans();
      for (int c = 0; c < EC; c++) ch_q[c] = '{5};
      run_pkt(1, 0, -1, 0, 0, 0);
      n_checks++;
      if (timed_out || got_d.size() != 4 || take_ch.size() != 4) begin
         n_errors++; $display("FAIL ties_count: got %0d out / %0d in expected 4/4", got_d.size(), take_ch.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (take_ch[i] != i || got_d[i] != 5) begin
               n_errors++; $display("FAIL ties_order[%0d]: got ch%0d data %0d expected ch%0d data 5",
                                    i, take_ch[i], got_d[i], i);
            end
         end
         n_checks++;
         if (got_len != 4 || got_eop[3] != 1'b1) begin
            n_errors++; $display("FAIL ties_len: got %0d eop=%b expected 4 eop=1", got_len, got_eop[3]);
         end
      end
      n_checks++;
      if (stall_bad != 0) begin n_errors++; $display("FAIL ties_stall_stable: got %0d changes expected 0", stall_bad); end
   endtask

   task automatic test_gap();
      do_reset(1'b0);
      clear_chans();
      ch_q[0] = '{1, 5, 9, 13}; ch_q[1] = '{2, 6, 10}; ch_q[2] = '{3, 7, 11}; ch_q[3] = '{4, 8, 12};
      run_pkt(0, 0, 2, 5, 3, 0);
      n_checks++;
      if (gap_xfers != 0 || gap_outs != 0) begin
         n_errors++; $display("FAIL gap_hold: got %0d transfers %0d outputs expected 0/0", gap_xfers, gap_outs);
      end
      n_checks++;
      if (timed_out || got_d.size() != 13) begin
         n_errors++; $display("FAIL gap_count: got %0d expected 13", got_d.size());
      end else begin
         for (int i = 0; i < 13; i++) begin
            n_checks++;
            if (got_d[i] != i + 1) begin
               n_errors++; $display("FAIL gap_word[%0d]: got %0d expected %0d", i, got_d[i], i + 1);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int unsigned exp_d[$];
      do_reset(1'b0);
      clear_chans();
      ch_q[0] = '{1, 5, 9}; ch_q[1] = '{2, 6}; ch_q[2] = '{0}; ch_q[3] = '{3, 4, 7, 8};
      run_pkt(0, 0, -1, 0, 0, 3);
      n_checks++;
      if (got_d.size() != 3 || got_d[0] != 0 || got_d[2] != 2) begin
         n_errors++; $display("FAIL rstmid_pre: got %0d words expected 0,1,2", got_d.size());
      end
      @(negedge clk); #1;
      n_checks++;
      if ({val_o, sop_o, eop_o, busy_o} !== 4'b0 || ready_o !== '0 || data_o !== '0 || len_o !== '0) begin
         n_errors++;
         $display("FAIL rstmid_outputs: got val=%b sop=%b eop=%b busy=%b rdy=%b data=%0d len=%0d, expected all 0",
                  val_o, sop_o, eop_o, busy_o, ready_o, data_o, len_o);
      end
      rst_n_i = 1'b1; desc_i = 1'b0; val_i = '0;
      clear_chans();
      ch_q[0] = '{10, 20}; ch_q[1] = '{15}; ch_q[2] = '{12, 30}; ch_q[3] = '{11};
      exp_d = '{10, 11, 12, 15, 20, 30};
      run_pkt(0, 0, -1, 0, 0, 0);
      n_checks++;
      if (timed_out || got_d.size() != 6) begin
         n_errors++; $display("FAIL rstmid_count: got %0d expected 6", got_d.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got_d[i] != exp_d[i] || got_sop[i] != (i == 0)) begin
               n_errors++; $display("FAIL rstmid_word[%0d]: got %0d sop=%b expected %0d sop=%b",
                                    i, got_d[i], got_sop[i], exp_d[i], i == 0);
            end
         end
      end
   endtask

   task automatic test_err();
      int unsigned exp_d[$];
      int          k, n1;
      do_reset(1'b0);
      clear_chans();
      ch_q[0] = '{1}; ch_q[1] = '{4, 2}; ch_q[2] = '{3}; ch_q[3] = '{5};
      exp_d = '{1, 3, 4, 2, 5};
      run_pkt(0, 0, -1, 0, 0, 0);
      n_checks++;
      if (timed_out || got_d.size() != 5) begin
         n_errors++; $display("FAIL err_count: got %0d expected 5", got_d.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (got_d[i] != exp_d[i]) begin
               n_errors++; $display("FAIL err_word[%0d]: got %0d expected %0d", i, got_d[i], exp_d[i]);
            end
         end
      end
      k = -1; n1 = 0;
      for (int i = 0; i < take_ch.size(); i++) begin
         if (take_ch[i] == 1) begin
            n1++;
            if (n1 == 2) k = take_cyc[i];
         end
      end
      n_checks++;
      if (k < 0) begin n_errors++; $display("FAIL err_take: got no second ch1 transfer expected one"); end
`ifdef SORT_MERGE_CHECK_EN
      if (k >= 0 && k + 1 < err_hist.size()) begin
         n_checks++;
         if (err_hist[k] !== 1'b0 || err_hist[k+1] !== 1'b1) begin
            n_errors++; $display("FAIL err_rise: got %b->%b expected 0->1", err_hist[k], err_hist[k+1]);
         end
      end
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (err_o !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b expected 1", err_o); end
      do_reset(1'b0);
      #1;
      n_checks++;
      if (err_o !== 1'b0) begin n_errors++; $display("FAIL err_clear: got %b expected 0", err_o); end
`endif
   endtask

   task automatic test_random();
      int unsigned exp_d[$], tmp[$];
      logic        d;
      for (int p = 0; p < 6; p++) begin
         d = 1'($urandom_range(0, 1));
         if (p == 0) do_reset(d);
         else begin
            @(negedge clk);
            desc_i = d;
         end
         clear_chans();
         exp_d.delete();
         for (int c = 0; c < EC; c++) begin
            tmp.delete();
            for (int n = $urandom_range(1, 6); n > 0; n--) tmp.push_back($urandom_range(0, 40));
            if (d) tmp.rsort(); else tmp.sort();
            foreach (tmp[i]) begin
               ch_q[c].push_back(tmp[i]);
               exp_d.push_back(tmp[i]);
            end
         end
         if (d) exp_d.rsort(); else exp_d.sort();
         run_pkt(2, 0, -1, 0, 0, 0);
         n_checks++;
         if (timed_out || got_d.size() != exp_d.size() || got_len != exp_d.size()) begin
            n_errors++; $display("FAIL rand%0d_count: got %0d words len %0d expected %0d",
                                 p, got_d.size(), got_len, exp_d.size());
         end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
               n_checks++;
               if (got_d[i] != exp_d[i] || got_sop[i] != (i == 0) || got_eop[i] != (i == exp_d.size() - 1)) begin
                  n_errors++; $display("FAIL rand%0d_word[%0d]: got %0d sop=%b eop=%b expected %0d",
                                       p, i, got_d[i], got_sop[i], got_eop[i], exp_d[i]);
               end
            end
         end
         n_checks++;
         if (stall_bad != 0) begin n_errors++; $display("FAIL rand%0d_stall: got %0d expected 0", p, stall_bad); end
      end
   endtask

   initial begin
      test_reset();
      test_asc();
      test_desc();
      test_ties();
      test_gap();
      test_reset_mid();
      test_err();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
